// File: rtl/ts_overflow_filter_pkg.sv
// Shared definitions for the TS overflow filter: frame type codes, FSM state
// encoding and control-word field offset helpers.
package tof_pkg;

    localparam logic [2:0] TYPE_TS_CT     = 3'b000;
    localparam logic [2:0] TYPE_TS_RC     = 3'b001;
    localparam logic [2:0] TYPE_TS_BE_MAP = 3'b010;
    localparam logic [2:0] TYPE_NMAC      = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_TRANS_DATA = 2'd1,
        ST_TRANS_NMAC = 2'd2,
        ST_DISC_DATA  = 2'd3
    } tof_state_e;

    // MSB position of the 3-bit type field inside the control word
    function automatic int tof_type_msb(input int ctrl_w);
        return ctrl_w - 1;
    endfunction

    // MSB position of the flow-id field, directly below the type field
    function automatic int tof_flow_msb(input int ctrl_w);
        return ctrl_w - 4;
    endfunction

    function automatic logic tof_is_ts(input logic [2:0] frm_type);
        return (frm_type == TYPE_TS_CT) || (frm_type == TYPE_TS_RC) ||
               (frm_type == TYPE_TS_BE_MAP);
    endfunction

endpackage

// File: rtl/ts_overflow_filter_if.sv
// Frame bus bundle: beat (payload plus delimiter bit), beat valid and the
// control word that accompanies the head beat.
interface ts_overflow_filter_if #(
    parameter int DATA_W = 8,
    parameter int CTRL_W = 19
);
    logic [DATA_W:0]   data;
    logic              data_wr;
    logic [CTRL_W-1:0] ctrl_data;

    modport master (output data, output data_wr, output ctrl_data);
    modport slave  (input  data, input  data_wr, input  ctrl_data);
endinterface

// File: rtl/ts_overflow_filter_drop_cnt_bank.sv
// Per-flow saturating drop counters with a clear-on-read port; a read that
// coincides with an increment of the same flow returns the old value and leaves 1.
module tof_drop_cnt_bank #(
    parameter int FLOW_NUM  = 32,
    parameter int FLOW_ID_W = $clog2(FLOW_NUM),
    parameter int CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    input  logic [FLOW_ID_W-1:0] iv_inc_addr,
    input  logic                 i_rd,
    input  logic [FLOW_ID_W-1:0] iv_rd_addr,
    output logic                 o_rd_valid,
    output logic [CNT_W-1:0]     ov_rd_data
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_all [FLOW_NUM];
    logic [CNT_W-1:0] rd_data_d, rd_data_q;
    logic             rd_valid_d, rd_valid_q;

    generate
        for (genvar gi = 0; gi < FLOW_NUM; gi++) begin : g_cnt
            logic             inc_hit;
            logic             rd_hit;
            logic [CNT_W-1:0] cnt_d, cnt_q;

            assign inc_hit = i_inc && (iv_inc_addr == FLOW_ID_W'(gi));
            assign rd_hit  = i_rd  && (iv_rd_addr  == FLOW_ID_W'(gi));

            always_comb begin
                cnt_d = cnt_q;
                if (rd_hit) begin
                    // clearing on read must not swallow a drop landing this cycle
                    cnt_d = inc_hit ? CNT_W'(1) : '0;
                end else if (inc_hit && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_all[gi] = cnt_q;
        end
    endgenerate

    always_comb begin
        rd_valid_d = i_rd;
        rd_data_d  = i_rd ? cnt_all[iv_rd_addr] : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign o_rd_valid = rd_valid_q;
    assign ov_rd_data = rd_data_q;

endmodule

// File: rtl/ts_overflow_filter.sv
// Per-flow TS overflow filter: diverts NMAC frames, drops TS frames of
// overflowing flows, forwards the rest. Optional drop counters: TOF_DROP_CNT_EN.
module ts_overflow_filter
    import tof_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int FLOW_NUM  = 32,
    parameter int FLOW_ID_W = $clog2(FLOW_NUM),
    parameter int CTRL_W    = 19,
    parameter int CNT_W     = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ts_overflow_filter_if.slave   rx_if,
    input  logic [FLOW_NUM-1:0]   iv_ts_cnt,
    output logic                  o_pkt_cnt_pulse,
    output logic [DATA_W:0]       ov_nmac_data,
    output logic                  o_nmac_data_wr,
    ts_overflow_filter_if.master  tx_if,
    output logic                  o_ts_overflow_error_pulse,
    output logic [FLOW_ID_W-1:0]  ov_drop_flow_id,
    input  logic                  i_cnt_rd,
    input  logic [FLOW_ID_W-1:0]  iv_cnt_rd_addr,
    output logic                  o_cnt_rd_valid,
    output logic [CNT_W-1:0]      ov_cnt_rd_data,
    output logic [1:0]            ov_tof_state
);

    localparam int TYPE_MSB = tof_type_msb(CTRL_W);
    localparam int FLOW_MSB = tof_flow_msb(CTRL_W);

    tof_state_e           state_d, state_q;
    logic [DATA_W:0]      data_d, data_q;
    logic                 data_wr_d, data_wr_q;
    logic [CTRL_W-1:0]    ctrl_d, ctrl_q;
    logic [DATA_W:0]      nmac_data_d, nmac_data_q;
    logic                 nmac_wr_d, nmac_wr_q;
    logic                 pkt_d, pkt_q;
    logic                 err_d, err_q;
    logic [FLOW_ID_W-1:0] drop_id_d, drop_id_q;
    logic                 drop_hit;

    logic                 delim;
    logic [2:0]           frm_type;
    logic [FLOW_ID_W-1:0] frm_flow;
    logic                 ts_flag;

    assign delim    = rx_if.data_wr & rx_if.data[DATA_W];
    assign frm_type = rx_if.ctrl_data[TYPE_MSB -: 3];
    assign frm_flow = rx_if.ctrl_data[FLOW_MSB -: FLOW_ID_W];
    assign ts_flag  = iv_ts_cnt[frm_flow];

    always_comb begin
        state_d     = state_q;
        data_d      = '0;
        data_wr_d   = 1'b0;
        ctrl_d      = '0;
        nmac_data_d = '0;
        nmac_wr_d   = 1'b0;
        pkt_d       = 1'b0;
        err_d       = 1'b0;
        drop_id_d   = drop_id_q;
        drop_hit    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // the disposition of the whole frame is fixed here, on the head beat
                if (delim) begin
                    pkt_d = 1'b1;
                    if (frm_type == TYPE_NMAC) begin
                        state_d     = ST_TRANS_NMAC;
                        nmac_data_d = rx_if.data;
                        nmac_wr_d   = 1'b1;
                    end else if (tof_is_ts(frm_type) && ts_flag) begin
                        state_d   = ST_DISC_DATA;
                        err_d     = 1'b1;
                        drop_id_d = frm_flow;
                        drop_hit  = 1'b1;
                    end else begin
                        state_d   = ST_TRANS_DATA;
                        data_d    = rx_if.data;
                        data_wr_d = 1'b1;
                        ctrl_d    = rx_if.ctrl_data;
                    end
                end
            end
            ST_TRANS_DATA: begin
                ctrl_d    = ctrl_q;
                data_wr_d = rx_if.data_wr;
                data_d    = rx_if.data_wr ? rx_if.data : '0;
                if (delim) state_d = ST_IDLE;
            end
            ST_TRANS_NMAC: begin
                nmac_wr_d   = rx_if.data_wr;
                nmac_data_d = rx_if.data_wr ? rx_if.data : '0;
                if (delim) state_d = ST_IDLE;
            end
            ST_DISC_DATA: begin
                if (delim) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            data_wr_q   <= 1'b0;
            ctrl_q      <= '0;
            nmac_data_q <= '0;
            nmac_wr_q   <= 1'b0;
            pkt_q       <= 1'b0;
            err_q       <= 1'b0;
            drop_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            data_wr_q   <= data_wr_d;
            ctrl_q      <= ctrl_d;
            nmac_data_q <= nmac_data_d;
            nmac_wr_q   <= nmac_wr_d;
            pkt_q       <= pkt_d;
            err_q       <= err_d;
            drop_id_q   <= drop_id_d;
        end
    end

    assign tx_if.data                = data_q;
    assign tx_if.data_wr             = data_wr_q;
    assign tx_if.ctrl_data           = ctrl_q;
    assign ov_nmac_data              = nmac_data_q;
    assign o_nmac_data_wr            = nmac_wr_q;
    assign o_pkt_cnt_pulse           = pkt_q;
    assign o_ts_overflow_error_pulse = err_q;
    assign ov_drop_flow_id           = drop_id_q;
    assign ov_tof_state              = state_q;

`ifdef TOF_DROP_CNT_EN
    tof_drop_cnt_bank #(
        .FLOW_NUM  (FLOW_NUM),
        .FLOW_ID_W (FLOW_ID_W),
        .CNT_W     (CNT_W)
    ) u_drop_cnt_bank (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (drop_hit),
        .iv_inc_addr (frm_flow),
        .i_rd        (i_cnt_rd),
        .iv_rd_addr  (iv_cnt_rd_addr),
        .o_rd_valid  (o_cnt_rd_valid),
        .ov_rd_data  (ov_cnt_rd_data)
    );
`else
    // without counters the read port still answers, always with zero
    logic rd_valid_q;
    logic unused_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= i_cnt_rd;
        end
    end

    assign o_cnt_rd_valid = rd_valid_q;
    assign ov_cnt_rd_data = '0;
    assign unused_cnt     = ^{iv_cnt_rd_addr, drop_hit};
`endif

endmodule

// File: tb/tb_ts_overflow_filter.sv
// Self-checking bench for ts_overflow_filter: directed frames from the test
// plan followed by randomized frames, checked cycle by cycle against a frame-level model.
module tb_ts_overflow_filter;

    localparam int DATA_W    = 8;
    localparam int FLOW_NUM  = 32;
    localparam int FLOW_ID_W = 5;
    localparam int CTRL_W    = 19;
    localparam int CNT_W     = 6;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [FLOW_NUM-1:0]  ts_cnt;
    logic                 cnt_rd;
    logic [FLOW_ID_W-1:0] cnt_rd_addr;
    logic                 pkt_pulse;
    logic [DATA_W:0]      nmac_data;
    logic                 nmac_wr;
    logic                 err_pulse;
    logic [FLOW_ID_W-1:0] drop_id;
    logic                 rd_valid;
    logic [CNT_W-1:0]     rd_data;
    logic [1:0]           tof_state;

    ts_overflow_filter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) rx_if ();
    ts_overflow_filter_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) tx_if ();

    ts_overflow_filter #(
        .DATA_W(DATA_W), .FLOW_NUM(FLOW_NUM), .FLOW_ID_W(FLOW_ID_W),
        .CTRL_W(CTRL_W), .CNT_W(CNT_W)
    ) dut (
        .i_clk                     (i_clk),
        .i_rst_n                   (i_rst_n),
        .rx_if                     (rx_if),
        .iv_ts_cnt                 (ts_cnt),
        .o_pkt_cnt_pulse           (pkt_pulse),
        .ov_nmac_data              (nmac_data),
        .o_nmac_data_wr            (nmac_wr),
        .tx_if                     (tx_if),
        .o_ts_overflow_error_pulse (err_pulse),
        .ov_drop_flow_id           (drop_id),
        .i_cnt_rd                  (cnt_rd),
        .iv_cnt_rd_addr            (cnt_rd_addr),
        .o_cnt_rd_valid            (rd_valid),
        .ov_cnt_rd_data            (rd_data),
        .ov_tof_state              (tof_state)
    );

    always #5 i_clk = ~i_clk;

    int n_chk = 0;
    int n_err = 0;
    int n_frames = 0;

    // frame-level reference: whether we are inside a frame and what its head decided
    bit                   in_frame;
    int                   disp;      // 1 forward, 2 nmac, 3 discard
    logic [CTRL_W-1:0]    hdr_ctrl;
    logic [FLOW_ID_W-1:0] m_drop_id;
    int                   m_cnt [FLOW_NUM];

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_frame  = 0;
        disp      = 0;
        hdr_ctrl  = '0;
        m_drop_id = '0;
        for (int i = 0; i < FLOW_NUM; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check_value({tag, "_data"},    64'(tx_if.data), 64'd0);
        check_value({tag, "_wr"},      64'(tx_if.data_wr), 64'd0);
        check_value({tag, "_ctrl"},    64'(tx_if.ctrl_data), 64'd0);
        check_value({tag, "_ndata"},   64'(nmac_data), 64'd0);
        check_value({tag, "_nwr"},     64'(nmac_wr), 64'd0);
        check_value({tag, "_pkt"},     64'(pkt_pulse), 64'd0);
        check_value({tag, "_err"},     64'(err_pulse), 64'd0);
        check_value({tag, "_dropid"},  64'(drop_id), 64'd0);
        check_value({tag, "_rdv"},     64'(rd_valid), 64'd0);
        check_value({tag, "_rdd"},     64'(rd_data), 64'd0);
        check_value({tag, "_state"},   64'(tof_state), 64'd0);
    endtask

    task automatic set_beat(input logic wr, input logic delim, input logic [DATA_W-1:0] pay,
                            input logic [CTRL_W-1:0] ctrl);
        rx_if.data_wr   = wr;
        rx_if.data      = {delim, pay};
        rx_if.ctrl_data = ctrl;
    endtask

    task automatic side_rand();
        ts_cnt      = FLOW_NUM'($urandom & $urandom);
        cnt_rd      = ($urandom_range(2) == 0);
        cnt_rd_addr = FLOW_ID_W'($urandom);
    endtask

    // compute expectations for the current inputs, clock once, compare
    task automatic tick();
        logic              delim;
        logic [2:0]        typ;
        int                flow;
        bit                inc;
        logic [DATA_W:0]   e_data, e_ndata;
        logic              e_wr, e_nwr, e_pkt, e_err, e_rdv;
        logic [CTRL_W-1:0] e_ctrl;
        logic [CNT_W-1:0]  e_rdd;
        e_data = '0; e_ndata = '0; e_wr = 0; e_nwr = 0; e_pkt = 0; e_err = 0;
        e_ctrl = '0; e_rdd = '0; inc = 0;
        delim = rx_if.data_wr && rx_if.data[DATA_W];
        typ   = rx_if.ctrl_data[CTRL_W-1 -: 3];
        flow  = int'(rx_if.ctrl_data[CTRL_W-4 -: FLOW_ID_W]);
        if (!in_frame) begin
            if (delim) begin
                e_pkt    = 1;
                in_frame = 1;
                if (typ == 3'b101) begin
                    disp = 2; e_ndata = rx_if.data; e_nwr = 1;
                end else if (typ <= 3'b010 && ts_cnt[flow]) begin
                    disp = 3; e_err = 1; m_drop_id = FLOW_ID_W'(flow); inc = 1;
                end else begin
                    disp = 1; hdr_ctrl = rx_if.ctrl_data;
                    e_data = rx_if.data; e_wr = 1; e_ctrl = hdr_ctrl;
                end
            end
        end else begin
            if (disp == 1) begin
                e_wr = rx_if.data_wr; e_ctrl = hdr_ctrl;
                e_data = rx_if.data_wr ? rx_if.data : '0;
            end else if (disp == 2) begin
                e_nwr = rx_if.data_wr;
                e_ndata = rx_if.data_wr ? rx_if.data : '0;
            end
            if (delim) in_frame = 0;
        end
        e_rdv = cnt_rd;
`ifdef TOF_DROP_CNT_EN
        if (cnt_rd) begin
            e_rdd = CNT_W'(m_cnt[cnt_rd_addr]);
            m_cnt[cnt_rd_addr] = 0;
        end
        if (inc) m_cnt[flow] = (m_cnt[flow] < CNT_MAX) ? m_cnt[flow] + 1 : CNT_MAX;
`endif
        @(posedge i_clk);
        #1;
        check_value("data",   64'(tx_if.data), 64'(e_data));
        check_value("wr",     64'(tx_if.data_wr), 64'(e_wr));
        check_value("ctrl",   64'(tx_if.ctrl_data), 64'(e_ctrl));
        check_value("ndata",  64'(nmac_data), 64'(e_ndata));
        check_value("nwr",    64'(nmac_wr), 64'(e_nwr));
        check_value("pkt",    64'(pkt_pulse), 64'(e_pkt));
        check_value("err",    64'(err_pulse), 64'(e_err));
        check_value("dropid", 64'(drop_id), 64'(m_drop_id));
        check_value("rdv",    64'(rd_valid), 64'(e_rdv));
        check_value("rdd",    64'(rd_data), 64'(e_rdd));
        check_value("state",  64'(tof_state), 64'(in_frame ? disp : 0));
    endtask

    task automatic idle_tick(input bit rnd_side);
        set_beat(1'b0, 1'($urandom), DATA_W'($urandom), CTRL_W'($urandom));
        if (rnd_side) side_rand();
        tick();
    endtask

    task automatic send_frame(input logic [2:0] typ, input int flow, input int len,
                              input int gap_pct, input bit rnd_side);
        logic [CTRL_W-1:0] c;
        n_frames++;
        $display("frame %0d: type=%03b flow=%0d len=%0d", n_frames, typ, flow, len);
        for (int b = 0; b < len; b++) begin
            if (b > 0)
                for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) idle_tick(rnd_side);
            c = CTRL_W'($urandom);
            if (b == 0) begin
                c[CTRL_W-1 -: 3] = typ;
                c[CTRL_W-4 -: FLOW_ID_W] = FLOW_ID_W'(flow);
            end
            set_beat(1'b1, (b == 0) || (b == len - 1), DATA_W'($urandom), c);
            if (rnd_side) side_rand();
            tick();
        end
        set_beat(1'b0, 1'b0, '0, '0);
    endtask

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [2:0] typ, input int flow);
        logic [CTRL_W-1:0] c;
        c = CTRL_W'($urandom);
        c[CTRL_W-1 -: 3] = typ;
        c[CTRL_W-4 -: FLOW_ID_W] = FLOW_ID_W'(flow);
        return c;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] typ_tab [8];
        typ_tab[0] = 3'b000; typ_tab[1] = 3'b001; typ_tab[2] = 3'b010; typ_tab[3] = 3'b101;
        typ_tab[4] = 3'b011; typ_tab[5] = 3'b100; typ_tab[6] = 3'b110; typ_tab[7] = 3'b111;

        i_rst_n = 1'b0;
        ts_cnt = '0; cnt_rd = 1'b0; cnt_rd_addr = '0;
        set_beat(1'b0, 1'b0, '0, '0);
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all_zero("reset");
        i_rst_n = 1'b1;

        // forwarded TS frame on flow 3
        send_frame(3'b000, 3, 4, 0, 0);
        idle_tick(0);

        // dropped TS frame on flow 7, then two clear-on-read reads
        ts_cnt = FLOW_NUM'(1) << 7;
        send_frame(3'b001, 7, 3, 0, 0);
        ts_cnt = '0;
        cnt_rd = 1'b1; cnt_rd_addr = 5'd7;
        idle_tick(0);
        idle_tick(0);
        cnt_rd = 1'b0;

        // NMAC frame with gaps between beats
        send_frame(3'b101, 9, 3, 100, 0);
        idle_tick(0);

        // overflow flag for flow 5 raised after the head beat
        ts_cnt = '0;
        n_frames++;
        $display("frame %0d: type=010 flow=5 len=3 flag raised mid-frame", n_frames);
        set_beat(1'b1, 1'b1, 8'h5a, mk_ctrl(3'b010, 5)); tick();
        ts_cnt = FLOW_NUM'(1) << 5;
        set_beat(1'b1, 1'b0, 8'h11, mk_ctrl(3'b010, 5)); tick();
        set_beat(1'b1, 1'b1, 8'h22, mk_ctrl(3'b010, 5)); tick();
        ts_cnt = '0;
        idle_tick(0);

        // saturation of flow 2, then a read that coincides with a drop
        ts_cnt = FLOW_NUM'(1) << 2;
        for (int i = 0; i < CNT_MAX + 1; i++) send_frame(3'b000, 2, 2, 0, 0);
        cnt_rd = 1'b1; cnt_rd_addr = 5'd2;
        send_frame(3'b000, 2, 2, 0, 0);
        cnt_rd = 1'b0;
        ts_cnt = '0;
        idle_tick(0);

        // reset in the middle of a forwarded frame
        n_frames++;
        $display("frame %0d: type=000 flow=4 cut by reset", n_frames);
        set_beat(1'b1, 1'b1, 8'h33, mk_ctrl(3'b000, 4)); tick();
        set_beat(1'b1, 1'b0, 8'h44, mk_ctrl(3'b000, 4)); tick();
        #3;
        i_rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        set_beat(1'b0, 1'b0, '0, '0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        set_beat(1'b1, 1'b0, 8'h55, mk_ctrl(3'b000, 4)); tick();
        set_beat(1'b1, 1'b1, 8'h66, mk_ctrl(3'b011, 6)); tick();
        set_beat(1'b1, 1'b0, 8'h77, mk_ctrl(3'b011, 6)); tick();
        set_beat(1'b1, 1'b1, 8'h88, mk_ctrl(3'b011, 6)); tick();
        send_frame(3'b000, 4, 3, 0, 0);

        // randomized frames with random flags, reads, gaps and junk between frames
        for (int f = 0; f < 300; f++) begin
            send_frame(typ_tab[$urandom_range(7)], int'($urandom_range(FLOW_NUM - 1)),
                       int'($urandom_range(6, 2)), 20, 1);
            for (int j = 0; j < int'($urandom_range(2)); j++) begin
                set_beat(1'b1, 1'b0, DATA_W'($urandom), CTRL_W'($urandom));
                side_rand();
                tick();
            end
        end
        cnt_rd = 1'b0;
        idle_tick(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ts_overflow_filter.md
# ts_overflow_filter

Parametrised per-flow TS overflow filter in the host receive path, in the packet map/dispatch stage. It classifies each incoming frame by the type field of its control word and diverts NMAC frames to the CSM port. TS frames whose flow is flagged as overflowing are discarded; all other frames are forwarded with their control word. It adds per-flow saturating drop counters with a clear-on-read port, and a registered drop event carrying the flow id.

## Interface
- DATA_W, 8: payload bits per beat; bit DATA_W of the data bus is the frame delimiter.
- FLOW_NUM, 32: number of TS flows monitored; must be a power of two, 2..256.
- FLOW_ID_W, $clog2(FLOW_NUM): flow-id width.
- CTRL_W, 19: control word width; type is [CTRL_W-1 -: 3], flow id is [CTRL_W-4 -: FLOW_ID_W].
- CNT_W, 16: drop-counter width.

Ports:
- i_clk  in  1  sole clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- iv_data  in  DATA_W+1  frame beat.
- i_data_wr  in  1  beat valid.
- iv_ctrl_data  in  CTRL_W  control word, valid on the head beat.
- iv_ts_cnt  in  FLOW_NUM  per-flow overflow flags; 1 means overflowing.
- o_pkt_cnt_pulse  out  1  one pulse per accepted head beat.
- ov_nmac_data / o_nmac_data_wr  out  DATA_W+1 / 1  NMAC frame output.
- ov_data / o_data_wr / ov_ctrl_data  out  DATA_W+1 / 1 / CTRL_W  forwarded frame output.
- o_ts_overflow_error_pulse  out  1  one pulse per dropped TS frame.
- ov_drop_flow_id  out  FLOW_ID_W  flow id of the latest drop; held until the next drop.
- i_cnt_rd / iv_cnt_rd_addr  in  1 / FLOW_ID_W  drop-counter read strobe and address.
- o_cnt_rd_valid / ov_cnt_rd_data  out  1 / CNT_W  read response.
- ov_tof_state  out  2  FSM state, for debug.

## Operation
- Head beat: i_data_wr=1 and delimiter=1 while the FSM is in IDLE.
- Tail beat: i_data_wr=1 and delimiter=1 in any other state.
- Minimum frame length is 2 beats.
- FSM states: IDLE=0, TRANS_DATA=1, TRANS_NMAC=2, DISC_DATA=3.
- IDLE, on a head beat:
  - Always pulse o_pkt_cnt_pulse.
  - Type 3'b101: go to TRANS_NMAC and forward the head beat on the NMAC output.
  - Type 000/001/010 (TS) with iv_ts_cnt[flow]=1: go to DISC_DATA, pulse o_ts_overflow_error_pulse, latch ov_drop_flow_id, and increment that flow's counter.
  - Anything else, or TS with the flag clear: go to TRANS_DATA and forward the beat plus ctrl word.
- The overflow flag is sampled only on the head beat; flag changes mid-frame do not affect that frame.
- TRANS_DATA / TRANS_NMAC:
  - Output mirrors the input one cycle later; o_*_wr follows i_data_wr, so gaps are preserved.
  - A tail beat returns the FSM to IDLE.
  - ov_ctrl_data holds its value for the whole frame.
- DISC_DATA: all write outputs stay 0; a tail beat returns the FSM to IDLE.
- Non-delimited beats in IDLE are ignored, and all outputs are driven to 0.
- Illegal state encodings cannot occur (2 bits, 4 states); default branch goes to IDLE with outputs cleared.
- Drop counters: one CNT_W counter per flow, saturating at all-ones.
  - A read on i_cnt_rd returns the counter value and clears it (clear-on-read).
  - Read and increment of the same flow in the same cycle: the read returns the old value and the counter becomes 1, so no drop is lost.
  - A saturated counter with a concurrent increment and read returns all-ones, and the counter becomes 1.

## Timing
- Data, NMAC, ctrl, pkt and error outputs: 1-cycle latency from the input beat.
- Read port: o_cnt_rd_valid and ov_cnt_rd_data appear 1 cycle after i_cnt_rd; back-to-back reads are supported every cycle.
- Reset, asynchronous:
  - All outputs go to 0, the FSM to IDLE, and all counters to 0.
  - A frame cut by reset is truncated with no tail on the output.
  - After reset, leftover beats are ignored until the next delimiter beat, which is treated as a head.

## Configuration
- TOF_DROP_CNT_EN:
  - Defined: the counter bank and read port are implemented.
  - Undefined: no counters are built; o_cnt_rd_valid still echoes i_cnt_rd one cycle later, and ov_cnt_rd_data=0.
  - Filtering, the error pulse and ov_drop_flow_id behave identically either way.

## Structure
- Shared package tof_pkg:
  - Type codes TYPE_TS_CT=3'b000, TYPE_TS_RC=3'b001, TYPE_TS_BE_MAP=3'b010, TYPE_NMAC=3'b101.
  - FSM state encoding.
  - Field-offset functions for the type and flow-id fields.
- Sub-module tof_drop_cnt_bank: the FLOW_NUM saturating counters and the clear-on-read logic, instantiated under TOF_DROP_CNT_EN.

## Test plan
- 4-beat TS frame on flow 3 with iv_ts_cnt=0 -> 4 beats on ov_data, 1-cycle delayed; ov_ctrl_data equals the input; one o_pkt_cnt_pulse; no error pulse.
- TS frame on flow 7 with iv_ts_cnt[7]=1 -> no o_data_wr; one error pulse; ov_drop_flow_id=7; a read of address 7 returns 1, then a second read returns 0.
- NMAC frame (type 101) with a one-cycle gap mid-frame -> beats on the NMAC output only, o_nmac_data_wr low during the gap; ov_data stays 0.
- iv_ts_cnt[5] set after the head of a forwarded flow-5 frame -> the whole frame is still forwarded.
- Flow 2 driven to 2^CNT_W-1 drops plus one more -> counter holds all-ones; a read coinciding with a drop returns all-ones, and the next read returns 1.
- Reset asserted in mid-frame of TRANS_DATA -> all outputs 0 immediately; the next delimited beat is treated as a head and processed normally.
